distance_reporter: RTL and testbench
====================================

# distance_reporter

Downstream consumer of the `tsp` core's `best_distance` / `best_distance_valid` outputs. Captures each new best tour distance and converts it to unsigned decimal ASCII. Streams the digits, then a line terminator, over a byte valid/ready handshake to the serial transmitter. Lets a host watch annealing progress as text lines.

## Interface
- `SUPPRESS_REPEATS`, default 1: when 1, a sampled value equal to the last captured value is not re-reported.
- `LINE_END`, default 8'h0D: terminator byte emitted after the last digit.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `best_distance` in 32: unsigned distance from `tsp`.
- `best_distance_valid` in 1: `best_distance` is meaningful this cycle; may stay high for many cycles.
- `tx_data` out 8: ASCII byte offered to the transmitter.
- `tx_valid` out 1: `tx_data` is offered.
- `tx_ready` in 1: transmitter accepts the byte.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CONVERT, SEND, EOL.
- **Capture rule.** A sample is a rising edge with `best_distance_valid`=1. It is "new" if either:
  - no value has been captured since reset, or
  - `SUPPRESS_REPEATS`=0, or
  - `best_distance` differs from the last captured value.
- **IDLE.** A new sample loads `best_distance` into the capture register and the conversion register, updates the last-captured register, and goes to CONVERT.
- **CONVERT.** Double-dabble over 32 iterations, one per cycle: a 40-bit BCD field (10 digits) plus a 32-bit shift field.
  - Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one.
  - An iteration counter of 0..31 ends the state.
  - Then go to SEND with the digit index set to the most-significant nonzero digit, or to digit 0 if all digits are zero.
- **SEND.**
  - `tx_data` = 8'h30 + current nibble.
  - On a transfer, decrement the digit index; the transfer after digit 0 goes to EOL.
- **EOL.** `tx_data` = `LINE_END`. On transfer:
  - if the pending slot is full, load it into conversion, clear it, and go to CONVERT with no IDLE cycle;
  - otherwise go to IDLE.
- **Pending slot (one deep).**
  - A new sample while busy writes the pending slot, overwriting any older pending value, and updates the last-captured register.
  - Only the newest value is ever reported after the current line.
- **Handshake.**
  - A transfer occurs on an edge with `tx_valid`=1 and `tx_ready`=1.
  - While `tx_valid`=1 and no transfer has occurred, `tx_data` and `tx_valid` hold stable.
  - `tx_valid`=1 exactly in SEND and EOL.
  - `tx_ready` is ignored in other states.

## Timing
- **Reset values:** `tx_data`=8'h00, `tx_valid`=0, `busy`=0, state IDLE, pending empty, "captured since reset" flag cleared.
- Capture at edge N.
- `busy`=1 from after edge N.
- CONVERT occupies edges N+1..N+32.
- After edge N+32, SEND is entered and `tx_valid`=1 with the first digit. First-byte latency is 32 cycles after the capture edge.
- With `tx_ready` held high, one byte transfers per cycle. A D-digit value finishes EOL at edge N+32+D+1.
- After EOL, `busy` falls the next cycle if no value is pending.
- Simultaneous events:
  - A new sample on the same edge as the EOL transfer is taken as pending, so CONVERT follows directly.
  - A sample on the edge that leaves IDLE counts as the capture, not as pending.
- **Reset mid-operation:** asynchronously forces every output to its reset value and drops `tx_valid` immediately. The partial line is abandoned and not resumed.
- **Width rules:**
  - 2^32−1 yields 10 digits; no overflow is possible.
  - The value 0 yields the single digit "0".
  - Nibbles never exceed 9 after conversion.

## Test plan
- Present 12345 for one cycle, `tx_ready`=1 → bytes 31 32 33 34 35 0D; first `tx_valid` 32 cycles after capture; `busy` low afterwards.
- Present 0, then 4294967295 (each after idle) → "0\r" then "4294967295\r"; no leading zeros.
- `SUPPRESS_REPEATS`=1, hold `best_distance_valid` high with 500 for 200 cycles → exactly one "500\r". With `SUPPRESS_REPEATS`=0, lines repeat back-to-back.
- Toggle `tx_ready` low 3 cycles out of every 4 while sending 987 → `tx_data` stable whenever stalled; byte order 39 38 37 0D; no byte lost or duplicated.
- While sending 1000, present 900 then 800 → "1000\r" then "800\r" only; CONVERT starts on the edge after the 0D transfer.
- Assert `rst` during the third digit of 65535 → `tx_valid`=0 immediately. After release, presenting 65535 again is reported in full, since the captured flag was cleared.

Source files
------------

// File: rtl/distance_reporter.sv
// distance_reporter: captures new best tour distances from the tsp core, converts each to
// unsigned decimal ASCII with a sequential double-dabble, and streams the digits followed by a
// line terminator over a byte valid/ready handshake.
//
// Parameters:
//   SUPPRESS_REPEATS - 1: a sample equal to the last captured value is not re-reported
//   LINE_END         - byte emitted after the last digit of each line
// Ports:
//   clk                 - clock, rising edge
//   rst                 - asynchronous active-high reset
//   best_distance       - unsigned distance from tsp
//   best_distance_valid - best_distance meaningful this cycle (may be held high)
//   tx_data             - ASCII byte offered to the transmitter
//   tx_valid            - tx_data is offered
//   tx_ready            - transmitter accepts the byte
//   busy                - high whenever a line is being converted or sent
module distance_reporter #(
  parameter bit         SUPPRESS_REPEATS = 1'b1,
  parameter logic [7:0] LINE_END         = 8'h0D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] best_distance,
  input  logic        best_distance_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StConvert, StSend, StEol} state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  iter_q, iter_d;
  logic [3:0]  digit_q, digit_d;
  logic [31:0] last_q, last_d;
  logic        captured_q, captured_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;

  logic        sample_new;
  logic        xfer;
  logic [39:0] bcd_step;
  logic [31:0] shift_step;
  logic [3:0]  top_digit;

  // Add 3 to every nibble that is 5 or more, so the following shift carries into the next digit.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] bcd);
    logic [39:0] res;
    res = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  assign sample_new = best_distance_valid &&
                      (!captured_q || !SUPPRESS_REPEATS || (best_distance != last_q));

  assign tx_valid = (state_q == StSend) || (state_q == StEol);
  assign busy     = (state_q != StIdle);
  assign xfer     = tx_valid && tx_ready;

  always_comb begin
    tx_data = 8'h00;
    if (state_q == StSend) tx_data = {4'h3, bcd_q[{digit_q, 2'b00} +: 4]};
    else if (state_q == StEol) tx_data = LINE_END;
  end

  // One double-dabble iteration and the most significant nonzero digit of its result.
  always_comb begin
    {bcd_step, shift_step} = {dabble_adjust(bcd_q), shift_q} << 1;
    top_digit = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (bcd_step[4*i +: 4] != 4'd0) top_digit = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    digit_d      = digit_q;
    last_d       = last_q;
    captured_d   = captured_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (sample_new) begin
      last_d     = best_distance;
      captured_d = 1'b1;
      // Anything arriving while busy lands in the pending slot; EOL may consume it below.
      if (state_q != StIdle) begin
        pend_d       = best_distance;
        pend_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sample_new) begin
          shift_d = best_distance;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        bcd_d   = bcd_step;
        shift_d = shift_step;
        iter_d  = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          digit_d = top_digit;
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (digit_q == 4'd0) state_d = StEol;
          else digit_d = digit_q - 4'd1;
        end
      end
      StEol: begin
        if (xfer) begin
          if (pend_valid_d) begin
            // pend_d already holds the newest value, including one sampled on this edge.
            shift_d      = pend_d;
            bcd_d        = '0;
            iter_d       = '0;
            pend_valid_d = 1'b0;
            state_d      = StConvert;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      digit_q      <= '0;
      last_q       <= '0;
      captured_q   <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      digit_q      <= digit_d;
      last_q       <= last_d;
      captured_q   <= captured_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: tb/tb_distance_reporter.sv
module tb_distance_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] best_distance;
  logic        best_distance_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  nr_data;
  logic        nr_valid;
  logic        nr_busy;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;
  int rphase = 0;
  int nr_lines = 0;
  logic [7:0] log_q[$];

  always #5 clk = ~clk;

  distance_reporter dut (
    .clk                 (clk),
    .rst                 (rst),
    .best_distance       (best_distance),
    .best_distance_valid (best_distance_valid),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy)
  );

  distance_reporter #(.SUPPRESS_REPEATS(1'b0)) dut_nr (
    .clk                 (clk),
    .rst                 (rst),
    .best_distance       (best_distance),
    .best_distance_valid (best_distance_valid),
    .tx_data             (nr_data),
    .tx_valid            (nr_valid),
    .tx_ready            (1'b1),
    .busy                (nr_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a line is the decimal text of the value plus CR, offered 32 cycles after
  // it is started; values arriving while a line is active collapse into one pending value.
  bit         m_cap;
  bit         m_pv;
  bit         m_active;
  logic [31:0] m_last;
  logic [31:0] m_pend;
  int         m_cnt;
  logic [7:0] m_line[$];

  function automatic void m_start(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    m_line.delete();
    do begin
      m_line.push_front(8'h30 + 8'(x % 32'd10));
      x = x / 32'd10;
    end while (x != 0);
    m_line.push_back(8'h0D);
    m_cnt    = 32;
    m_active = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cap    = 1'b0;
      m_pv     = 1'b0;
      m_active = 1'b0;
      m_cnt    = 0;
      m_line.delete();
    end else begin
      bit nw;
      bit xf;
      nw = best_distance_valid && (!m_cap || best_distance != m_last);
      xf = m_active && m_cnt == 0 && m_line.size() > 0 && tx_ready;
      if (!m_active) begin
        if (nw) m_start(best_distance);
      end else begin
        if (nw) begin
          m_pend = best_distance;
          m_pv   = 1'b1;
        end
        if (m_cnt > 0) m_cnt--;
        else if (xf) begin
          void'(m_line.pop_front());
          if (m_line.size() == 0) begin
            if (m_pv) begin
              m_pv = 1'b0;
              m_start(m_pend);
            end else begin
              m_active = 1'b0;
            end
          end
        end
      end
      if (nw) begin
        m_cap  = 1'b1;
        m_last = best_distance;
      end
    end
  end

  // Compare every cycle against the model; also log transfers and count repeat-DUT lines.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_v;
      exp_v = m_active && m_cnt == 0 && m_line.size() > 0;
      check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_v});
      check("busy", {31'b0, busy}, {31'b0, m_active});
      if (exp_v) check("tx_data", {24'b0, tx_data}, {24'b0, m_line[0]});
      if (tx_valid && tx_ready) log_q.push_back(tx_data);
      if (nr_valid && nr_data == 8'h0D) nr_lines++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin
        tx_ready = (rphase % 4 == 3);
        rphase++;
      end
      2: tx_ready = 1'($urandom % 2);
      default: tx_ready = 1'b1;
    endcase
  end

  task automatic present(input logic [31:0] v);
    @(posedge clk);
    #1;
    best_distance       = v;
    best_distance_valid = 1'b1;
    @(posedge clk);
    #1;
    best_distance_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    check(name, {31'b0, busy}, 32'd0);
  endtask

  // '|' in the expected text stands for the CR terminator.
  task automatic expect_log(input string name, input string s);
    logic [7:0] b;
    check({name, " length"}, log_q.size(), s.len());
    for (int i = 0; i < s.len() && i < log_q.size(); i++) begin
      b = s[i];
      if (b == 8'h7C) b = 8'h0D;
      check({name, " byte"}, {24'b0, log_q[i]}, {24'b0, b});
    end
    log_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int r;
    rst                 = 1'b1;
    best_distance       = '0;
    best_distance_valid = 1'b0;
    tx_ready            = 1'b1;
    repeat (2) @(negedge clk);
    check("reset tx_data", {24'b0, tx_data}, 32'h00);
    check("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    #2 rst = 1'b0;

    // 12345: first byte 32 cycles after capture.
    present(32'd12345);
    check("busy after capture", {31'b0, busy}, 32'd1);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    check("first byte latency", n, 32'd32);
    wait_idle("idle after 12345", 100);
    expect_log("line 12345", "12345|");

    present(32'd0);
    wait_idle("idle after 0", 100);
    present(32'hFFFF_FFFF);
    wait_idle("idle after max", 100);
    expect_log("lines 0 and max", "0|4294967295|");

    // Held valid: one line with suppression, back-to-back lines without.
    nr_lines = 0;
    @(posedge clk);
    #1;
    best_distance       = 32'd500;
    best_distance_valid = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    best_distance_valid = 1'b0;
    wait_idle("idle after hold", 200);
    expect_log("held 500", "500|");
    check("repeat lines without suppression", {31'b0, nr_lines >= 4}, 32'd1);

    // Stalled transmitter.
    rmode = 1;
    present(32'd987);
    wait_idle("idle after 987", 400);
    rmode = 0;
    expect_log("stalled 987", "987|");

    // Newer values overwrite the pending slot.
    present(32'd1000);
    repeat (5) @(posedge clk);
    present(32'd900);
    repeat (5) @(posedge clk);
    present(32'd800);
    wait_idle("idle after pending", 200);
    expect_log("pending overwrite", "1000|800|");

    // Reset during the third digit of 65535.
    present(32'd65535);
    k = 0;
    for (n = 0; n < 100 && k < 3; n++) begin
      @(negedge clk);
      if (tx_valid) k++;
    end
    check("reached third digit", k, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid reset tx_valid", {31'b0, tx_valid}, 32'd0);
    check("mid reset busy", {31'b0, busy}, 32'd0);
    check("mid reset tx_data", {24'b0, tx_data}, 32'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    log_q.delete();
    present(32'd65535);
    wait_idle("idle after re-present", 100);
    expect_log("65535 after reset", "65535|");

    // Random traffic against the model.
    rmode = 2;
    repeat (600) begin
      @(posedge clk);
      #1;
      best_distance_valid = ($urandom % 6 == 0);
      r = $urandom % 4;
      if (r == 0) best_distance = $urandom;
      else if (r == 1) best_distance = $urandom % 1000;
      else if (r == 2) best_distance = 32'd42;
    end
    best_distance_valid = 1'b0;
    wait_idle("idle after random", 400);
    rmode = 0;
    log_q.delete();

    n = 0;
    while (nr_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("repeat instance idle", {31'b0, nr_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
